weight_fetch_ctrl: RTL and testbench
====================================

Name: weight_fetch_ctrl

Overview:
Parametrised weight-fetch address generator for the quantised accelerator's weight BRAMs. Each start pulse launches one burst of BURST_LEN reads, column-descending within a row, to the currently active bank group. It advances the row pointer after each burst and rotates round-robin across NUM_GRP bank groups every PP_ROWS rows. This generalises the fixed 2-group, 32-read, 4-bank loader to arbitrary group count, banks per group, burst length and rotation point, and adds busy, done, flush and group-select outputs.

Parameters:
NUM_GRP, 2, number of bank groups rotated round-robin (>=1)
BANKS_PER_GRP, 2, banks per group; all banks in a group share enable and address
BURST_LEN, 32, reads per burst; power of 2, >=2
ROW_W, 7, row-pointer width
PP_ROWS, 127, rows per group before rotating; 1..2^ROW_W
ADDR_LSB, 3, left shift applied to the word index (bytes per word = 2^ADDR_LSB)
ADDR_W, 15, output address width; must be >= ROW_W+log2(BURST_LEN)+ADDR_LSB

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  single-cycle burst request
flush  input  1  synchronous abort; clears row and group pointers
busy  output  1  high while a burst is issuing
done  output  1  one-cycle pulse after the last read of a burst
grp_sel  output  max(1,$clog2(NUM_GRP))  group the next or current burst targets
bce  output  NUM_GRP*BANKS_PER_GRP  per-bank read enable; group g owns bits [g*BANKS_PER_GRP +: BANKS_PER_GRP]
braddr  output  NUM_GRP*BANKS_PER_GRP*ADDR_W  per-bank read address, packed in the same order as bce

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs 0, FSM in IDLE, row=0, col=0, grp=0.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE: start=1 -> ISSUE, with col loaded to BURST_LEN-1.
  - ISSUE: col decrements each cycle; when col==0 -> DONE.
  - DONE: one cycle, then -> IDLE.
- All outputs are registered. For start at edge T:
  - bce of active group is high on cycles T+1 .. T+BURST_LEN; busy is high over the same window.
  - braddr of the active group = ((row*BURST_LEN)+col) << ADDR_LSB, zero-extended to ADDR_W.
  - Addresses are issued in order col = BURST_LEN-1 down to 0.
  - done is high on cycle T+BURST_LEN+1.
- Inactive groups: bce held 0; braddr holds its last value. The active group's braddr also holds its last value while idle.
- Row advance at the DONE edge:
  - row < PP_ROWS-1: row+1.
  - row == PP_ROWS-1: row=0 and grp=(grp+1) mod NUM_GRP.
  - grp_sel reflects the new grp from the following cycle.
- start while not in IDLE (ISSUE or DONE): ignored; no queuing.
- start in the same cycle as done: treated as a new request, since the FSM is back in IDLE on the next edge. Back-to-back bursts therefore have a 1-cycle gap.
- flush (priority over start):
  - Any state -> IDLE; row=0, grp=0, all bce=0 on the next cycle.
  - done is not pulsed; braddr is held.
- rst_n low mid-burst: same as the reset values on the next edge.

Optional Feature:
WEIGHT_FETCH_DIR_SEL_EN
- Defined: adds input port dir (1 bit), sampled together with start. dir=1 issues col ascending 0..BURST_LEN-1; dir=0 issues descending. Timing and row advance are unchanged.
- Undefined: no dir port; order is always descending.

Decomposition:
- Shared package wfc_pkg:
  - FSM state enum wfc_state_t (IDLE, ISSUE, DONE).
  - Localparam helper functions for the column width ($clog2(BURST_LEN)) and the group-select width.
- Sub-module wfc_ptr: encapsulates the row/group pointer and its rotation, exposing advance, flush, row and grp.
- The top level holds the FSM, the column counter and the per-bank output registers.

Test Plan:
- Defaults, start at cycle 10:
  - bce[1:0] = 2'b11 on cycles 11..42.
  - braddr0 sequence: 248, 240, ..., 0.
  - done pulses at cycle 43; bce[3:2] stays 0 throughout.
- Rotation, PP_ROWS=2, NUM_GRP=3: issue 6 bursts.
  - Group order is 0, 0, 1, 1, 2, 2, then back to 0.
  - Second burst's first address is (1*32+31)<<3 = 504.
- start pulsed during ISSUE (cycle T+5): ignored. Exactly 32 enables, a single done, and the row advances by one.
- flush at cycle T+10 of a burst: bce=0 from T+11, no done pulse. The next start issues row 0, group 0, first address 248.
- rst_n=0 for one cycle mid-burst: all outputs 0 on the following cycle. The next start issues first address 248 to group 0.
- WEIGHT_FETCH_DIR_SEL_EN defined with dir=1: braddr sequence 0, 8, ..., 248, with done at T+33.

Source files
------------

// File: rtl/wfc_pkg.sv
// Shared types and width helpers for the weight-fetch controller.
// Provides the FSM state enum and the column / group-select widths.
package wfc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } wfc_state_t;

  function automatic int col_w(input int bl);
    return (bl > 1) ? $clog2(bl) : 1;
  endfunction

  function automatic int grp_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wfc_ptr.sv
// Row / bank-group pointer with round-robin group rotation.
// Ports: clk, rst_n, advance_i, flush_i, row_nxt_o, grp_nxt_o, grp_o.
module wfc_ptr
  import wfc_pkg::*;
#(
  parameter int NUM_GRP = 2,
  parameter int ROW_W   = 7,
  parameter int PP_ROWS = 127,
  parameter int GW      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             flush_i,
  output logic [ROW_W-1:0] row_nxt_o,
  output logic [GW-1:0]    grp_nxt_o,
  output logic [GW-1:0]    grp_o
);

  localparam logic [ROW_W-1:0] ROW_LAST =
    ROW_W'(PP_ROWS - 1);
  localparam logic [GW-1:0] GRP_LAST =
    GW'(NUM_GRP - 1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [GW-1:0]    grp_q, grp_d;

  always_comb begin
    row_d = row_q;
    grp_d = grp_q;
    if (flush_i) begin
      row_d = '0;
      grp_d = '0;
    end else if (advance_i) begin
      if (row_q == ROW_LAST) begin
        row_d = '0;
        grp_d = (grp_q == GRP_LAST) ? '0
                                    : grp_q + 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q <= '0;
      grp_q <= '0;
    end else begin
      row_q <= row_d;
      grp_q <= grp_d;
    end
  end

  // next values let a burst launched in DONE
  // target the freshly advanced row/group
  assign row_nxt_o = row_d;
  assign grp_nxt_o = grp_d;
  assign grp_o     = grp_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight-BRAM burst address generator: FSM, column counter, bank regs.
// Ports: clk rst_n start flush [dir] -> busy done grp_sel bce braddr. Macro WEIGHT_FETCH_DIR_SEL_EN adds dir.
module weight_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int NUM_GRP       = 2,
  parameter int BANKS_PER_GRP = 2,
  parameter int BURST_LEN     = 32,
  parameter int ROW_W         = 7,
  parameter int PP_ROWS       = 127,
  parameter int ADDR_LSB      = 3,
  parameter int ADDR_W        = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic flush,
`ifdef WEIGHT_FETCH_DIR_SEL_EN
  input  logic dir,
`endif
  output logic busy,
  output logic done,
  output logic [grp_w(NUM_GRP)-1:0] grp_sel,
  output logic [NUM_GRP*BANKS_PER_GRP-1:0] bce,
  output logic [NUM_GRP*BANKS_PER_GRP*ADDR_W-1:0] braddr
);

  localparam int CW = col_w(BURST_LEN);
  localparam int GW = grp_w(NUM_GRP);
  localparam int B  = BANKS_PER_GRP;
  localparam int NB = NUM_GRP * B;
  localparam logic [CW-1:0] COL_MAX =
    CW'(BURST_LEN - 1);

  wfc_state_t state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic launch, advance;
  logic dir_q, start_dir;
  logic [ROW_W-1:0] row_nxt;
  logic [GW-1:0] grp_nxt, grp_q;
  logic [ADDR_W-1:0] addr;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [NB-1:0] bce_q, bce_d;
  logic [NB*ADDR_W-1:0] ba_q, ba_d;

`ifdef WEIGHT_FETCH_DIR_SEL_EN
  assign start_dir = dir;
  always_ff @(posedge clk) begin
    if (!rst_n)
      dir_q <= 1'b0;
    else if (launch)
      dir_q <= dir;
  end
`else
  assign start_dir = 1'b0;
  assign dir_q     = 1'b0;
`endif

  wfc_ptr #(
    .NUM_GRP (NUM_GRP),
    .ROW_W   (ROW_W),
    .PP_ROWS (PP_ROWS),
    .GW      (GW)
  ) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance_i (advance),
    .flush_i   (flush),
    .row_nxt_o (row_nxt),
    .grp_nxt_o (grp_nxt),
    .grp_o     (grp_q)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    launch  = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) launch = 1'b1;
      end
      ISSUE: begin
        if (col_q == (dir_q ? COL_MAX : '0))
          state_d = DONE;
        else if (dir_q)
          col_d = col_q + 1'b1;
        else
          col_d = col_q - 1'b1;
      end
      DONE: begin
        advance = 1'b1;
        state_d = IDLE;
        // FSM is idle at this edge anyway, so a
        // start here chains with a 1-cycle gap
        if (start) launch = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      launch  = 1'b0;
      advance = 1'b0;
      state_d = IDLE;
    end
    if (launch) begin
      state_d = ISSUE;
      col_d   = start_dir ? '0 : COL_MAX;
    end
  end

  // {row,col} equals row*BURST_LEN+col
  assign addr = ADDR_W'({row_nxt, col_d})
                << ADDR_LSB;

  always_comb begin
    busy_d = (state_d == ISSUE);
    done_d = (state_d == DONE);
    bce_d  = '0;
    ba_d   = ba_q;
    if (state_d == ISSUE) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (grp_nxt == GW'(g)) begin
          for (int b = 0; b < B; b++) begin
            bce_d[g*B+b] = 1'b1;
            ba_d[(g*B+b)*ADDR_W +: ADDR_W] = addr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bce_q   <= '0;
      ba_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bce_q   <= bce_d;
      ba_q    <= ba_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign grp_sel = grp_q;
  assign bce     = bce_q;
  assign braddr  = ba_q;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Directed bench for weight_fetch_ctrl.
// Instance a: defaults; instance b: NUM_GRP=3, PP_ROWS=2.
module tb_weight_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, flush_a, dir_a;
  logic start_b, flush_b, dir_b;
  logic busy_a, done_a, busy_b, done_b;
  logic [0:0]  grp_a;
  logic [1:0]  grp_b;
  logic [3:0]  bce_a;
  logic [5:0]  bce_b;
  logic [59:0] ba_a;
  logic [89:0] ba_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  weight_fetch_ctrl u_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_a),
    .flush   (flush_a),
`ifdef WEIGHT_FETCH_DIR_SEL_EN
    .dir     (dir_a),
`endif
    .busy    (busy_a),
    .done    (done_a),
    .grp_sel (grp_a),
    .bce     (bce_a),
    .braddr  (ba_a)
  );

  weight_fetch_ctrl #(
    .NUM_GRP (3),
    .PP_ROWS (2)
  ) u_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_b),
    .flush   (flush_b),
`ifdef WEIGHT_FETCH_DIR_SEL_EN
    .dir     (dir_b),
`endif
    .busy    (busy_b),
    .done    (done_b),
    .grp_sel (grp_b),
    .bce     (bce_b),
    .braddr  (ba_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bce_a !== 4'b0 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || grp_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a_ctl: bce=%b busy=%b done=%b grp=%b want 0",
               bce_a, busy_a, done_a, grp_a);
    end
    checks++;
    if (ba_a !== 60'd0 || ba_b !== 90'd0 ||
        bce_b !== 6'd0 || grp_b !== 2'd0) begin
      errors++;
      $display("FAIL reset_addr: ba_a=%h ba_b=%h bce_b=%b grp_b=%0d want 0",
               ba_a, ba_b, bce_b, grp_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // row 0 -> 1
  task automatic test_burst();
    logic [14:0] exp;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp = 15'((31 - i) * 8);
      checks++;
      if (bce_a !== 4'b0011 || busy_a !== 1'b1 ||
          done_a !== 1'b0) begin
        errors++;
        $display("FAIL burst_ctl beat %0d: bce=%b busy=%b done=%b want 0011/1/0",
                 i, bce_a, busy_a, done_a);
      end
      checks++;
      if (ba_a[14:0] !== exp || ba_a[29:15] !== exp) begin
        errors++;
        $display("FAIL burst_addr beat %0d: b0=%0d b1=%0d want %0d",
                 i, ba_a[14:0], ba_a[29:15], exp);
      end
      tick();
    end
    checks++;
    if (done_a !== 1'b1 || bce_a !== 4'b0 ||
        busy_a !== 1'b0) begin
      errors++;
      $display("FAIL burst_done: done=%b bce=%b busy=%b want 1/0/0",
               done_a, bce_a, busy_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL burst_done_pulse: done=%b want 0", done_a);
    end
  endtask

  // row 1 -> 2
  task automatic test_ignore_start();
    int nbce, ndone;
    nbce  = 0;
    ndone = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (ba_a[14:0] !== 15'd504) begin
      errors++;
      $display("FAIL ignore_first_addr: got %0d want 504", ba_a[14:0]);
    end
    for (int c = 0; c < 40; c++) begin
      start_a = (c == 4);
      if (bce_a == 4'b0011) nbce++;
      if (done_a) ndone++;
      tick();
    end
    start_a = 1'b0;
    checks++;
    if (nbce != 32 || ndone != 1) begin
      errors++;
      $display("FAIL ignore_counts: enables=%0d dones=%0d want 32/1",
               nbce, ndone);
    end
  endtask

  // row 2 then row 3 -> 4
  task automatic test_back_to_back();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (ba_a[14:0] !== 15'd760) begin
      errors++;
      $display("FAIL b2b_first: got %0d want 760", ba_a[14:0]);
    end
    for (int i = 0; i < 32; i++) tick();
    checks++;
    if (done_a !== 1'b1 || bce_a !== 4'b0) begin
      errors++;
      $display("FAIL b2b_gap: done=%b bce=%b want 1/0", done_a, bce_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (bce_a !== 4'b0011 || ba_a[14:0] !== 15'd1016) begin
      errors++;
      $display("FAIL b2b_second: bce=%b addr=%0d want 0011/1016",
               bce_a, ba_a[14:0]);
    end
    for (int i = 0; i < 31; i++) tick();
    checks++;
    if (ba_a[14:0] !== 15'd768 || bce_a !== 4'b0011) begin
      errors++;
      $display("FAIL b2b_last: addr=%0d bce=%b want 768/0011",
               ba_a[14:0], bce_a);
    end
    tick();
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b want 1", done_a);
    end
    tick();
  endtask

  // row 4 flushed, then row 0 -> 1
  task automatic test_flush();
    int ndone;
    ndone = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    checks++;
    if (bce_a !== 4'b0 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || grp_a !== 1'b0) begin
      errors++;
      $display("FAIL flush_ctl: bce=%b busy=%b done=%b grp=%b want 0",
               bce_a, busy_a, done_a, grp_a);
    end
    checks++;
    if (ba_a[14:0] !== 15'd1200) begin
      errors++;
      $display("FAIL flush_hold: addr=%0d want 1200", ba_a[14:0]);
    end
    for (int c = 0; c < 30; c++) begin
      if (done_a || bce_a != 4'b0) ndone++;
      tick();
    end
    checks++;
    if (ndone != 0) begin
      errors++;
      $display("FAIL flush_quiet: activity=%0d want 0", ndone);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (bce_a !== 4'b0011 || ba_a[14:0] !== 15'd248) begin
      errors++;
      $display("FAIL flush_restart: bce=%b addr=%0d want 0011/248",
               bce_a, ba_a[14:0]);
    end
    for (int i = 0; i < 32; i++) tick();
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: done=%b want 1", done_a);
    end
    tick();
  endtask

  // row 1 aborted by reset, then row 0 -> 1
  task automatic test_reset_mid();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bce_a !== 4'b0 || busy_a !== 1'b0 ||
        done_a !== 1'b0 || ba_a !== 60'd0 ||
        grp_a !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outs: bce=%b busy=%b done=%b ba=%h want 0",
               bce_a, busy_a, done_a, ba_a);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    checks++;
    if (bce_a !== 4'b0011 || ba_a[14:0] !== 15'd248) begin
      errors++;
      $display("FAIL rstmid_restart: bce=%b addr=%0d want 0011/248",
               bce_a, ba_a[14:0]);
    end
    for (int i = 0; i < 32; i++) tick();
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_done: done=%b want 1", done_a);
    end
    tick();
  endtask

  task automatic test_rotation();
    int g, r;
    logic [5:0]  ebce;
    logic [14:0] eaddr;
    for (int k = 0; k < 7; k++) begin
      g = (k / 2) % 3;
      r = k % 2;
      ebce  = 6'(3 << (2 * g));
      eaddr = 15'((r * 32 + 31) * 8);
      checks++;
      if (grp_b !== 2'(g)) begin
        errors++;
        $display("FAIL rot_grp burst %0d: grp_sel=%0d want %0d",
                 k, grp_b, g);
      end
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      checks++;
      if (bce_b !== ebce ||
          ba_b[g*30 +: 15] !== eaddr) begin
        errors++;
        $display("FAIL rot_issue burst %0d: bce=%b addr=%0d want %b/%0d",
                 k, bce_b, ba_b[g*30 +: 15], ebce, eaddr);
      end
      for (int i = 0; i < 32; i++) tick();
      checks++;
      if (done_b !== 1'b1) begin
        errors++;
        $display("FAIL rot_done burst %0d: done=%b want 1", k, done_b);
      end
      tick();
    end
    checks++;
    if (grp_b !== 2'd0) begin
      errors++;
      $display("FAIL rot_wrap: grp_sel=%0d want 0", grp_b);
    end
  endtask

`ifdef WEIGHT_FETCH_DIR_SEL_EN
  task automatic test_dir();
    logic [14:0] exp;
    flush_a = 1'b1;
    tick();
    flush_a = 1'b0;
    dir_a   = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    dir_a   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp = 15'(i * 8);
      checks++;
      if (ba_a[14:0] !== exp || bce_a !== 4'b0011) begin
        errors++;
        $display("FAIL dir_addr beat %0d: addr=%0d bce=%b want %0d/0011",
                 i, ba_a[14:0], bce_a, exp);
      end
      tick();
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL dir_done: done=%b want 1", done_a);
    end
    tick();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    flush_a = 1'b0;
    dir_a   = 1'b0;
    start_b = 1'b0;
    flush_b = 1'b0;
    dir_b   = 1'b0;
    test_reset();
    test_rotation();
    test_burst();
    test_ignore_start();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef WEIGHT_FETCH_DIR_SEL_EN
    test_dir();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
